// File: rtl/uart_tx_serializer.sv
// Pops 32-bit words from the transmit FIFO and serializes them as async UART
// frames (byte 0 first, LSB first) with a clk-derived bit timer.
module uart_tx_serializer #(
  parameter int CLK_DIV        = 16,
  parameter int BYTES_PER_WORD = 4,
  parameter int PARITY_EN      = 0,
  parameter int PARITY_ODD     = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_en,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic        fifo_valid,
  input  logic [31:0] fifo_data,
  output logic        tx,
  output logic        busy,
  output logic        byte_done,
  output logic        word_done
);

  localparam int            BW        = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLK_DIV - 1);
  localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   shift_q, shift_d;
  logic          fifo_rd_q, fifo_rd_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          byte_done_q, byte_done_d;
  logic          word_done_q, word_done_d;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    fifo_rd_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fifo_valid) begin
          shift_d    = fifo_data;
          byte_idx_d = 2'd0;
          baud_d     = BAUD_LOAD;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d    = BAUD_LOAD;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_PARITY: begin
        if (baud_q == '0) begin
          baud_d     = BAUD_LOAD;
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (stop_idx_q == LAST_STOP) begin
            // Next byte starts back-to-back; no idle gap inside a word.
            if (byte_idx_q < LAST_BYTE) begin
              byte_idx_d = byte_idx_q + 2'd1;
              shift_d    = {8'h00, shift_q[31:8]};
              state_d    = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_idx_d];
      S_PARITY: tx_d = (^shift_d[7:0]) ^ ODD_BIT;
      default:  tx_d = 1'b1;
    endcase
    busy_d      = (state_d != S_IDLE);
    byte_done_d = (state_d == S_STOP) && (baud_d == '0) && (stop_idx_d == LAST_STOP);
    word_done_d = byte_done_d && (byte_idx_d == LAST_BYTE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      byte_idx_q  <= 2'd0;
      shift_q     <= 32'd0;
      fifo_rd_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      fifo_rd_q   <= fifo_rd_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      word_done_q <= word_done_d;
    end
  end

  assign fifo_rd   = fifo_rd_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign byte_done = byte_done_q;
  assign word_done = word_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: instance 0 is 8N1 with 4 bytes per
// word, instance 1 is 8E2 with 1 byte per word; both compared to a frame model.
module tb_uart_tx_serializer;

   localparam int CDIV = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  tx_en;
   logic [1:0]  fifo_empty;
   logic [1:0]  fifo_valid;
   logic [31:0] fifo_data [2];
   logic [1:0]  fifo_rd;
   logic [1:0]  tx;
   logic [1:0]  busy;
   logic [1:0]  byte_done;
   logic [1:0]  word_done;

   int total = 0;
   int bad   = 0;
   bit exp_bits[$];

   always #5 clk = ~clk;

   uart_tx_serializer #(
      .CLK_DIV(CDIV), .BYTES_PER_WORD(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
   ) dut_a (
      .clk(clk), .reset(reset), .tx_en(tx_en[0]), .fifo_empty(fifo_empty[0]),
      .fifo_rd(fifo_rd[0]), .fifo_valid(fifo_valid[0]), .fifo_data(fifo_data[0]),
      .tx(tx[0]), .busy(busy[0]), .byte_done(byte_done[0]), .word_done(word_done[0])
   );

   uart_tx_serializer #(
      .CLK_DIV(CDIV), .BYTES_PER_WORD(1), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
   ) dut_b (
      .clk(clk), .reset(reset), .tx_en(tx_en[1]), .fifo_empty(fifo_empty[1]),
      .fifo_rd(fifo_rd[1]), .fifo_valid(fifo_valid[1]), .fifo_data(fifo_data[1]),
      .tx(tx[1]), .busy(busy[1]), .byte_done(byte_done[1]), .word_done(word_done[1])
   );

   function automatic int bpwOf(int sel);
      return (sel == 0) ? 4 : 1;
   endfunction

   function automatic int parOf(int sel);
      return (sel == 0) ? 0 : 1;
   endfunction

   function automatic int stopOf(int sel);
      return (sel == 0) ? 1 : 2;
   endfunction

   // Line levels for a whole word, one entry per bit period.
   function automatic void buildExpected(int sel, logic [31:0] word);
      exp_bits.delete();
      for (int b = 0; b < bpwOf(sel); b++) begin
         logic [7:0] by;
         by = 8'((word >> (8 * b)) & 32'hFF);
         exp_bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) exp_bits.push_back(by[i]);
         if (parOf(sel) != 0) exp_bits.push_back(bit'(($countones(by) % 2) == 1));
         for (int s = 0; s < stopOf(sel); s++) exp_bits.push_back(1'b1);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   // One complete word on instance sel: pop, delayed fifo_valid, then cycle checks.
   task automatic applyStimulus(input int sel, input logic [31:0] word, input int lat,
                                input bit keep_full, input bit drop_en, input int abort_at);
      int waited;
      int n;
      int frame;
      waited = 0;
      tx_en[sel]      = 1'b1;
      fifo_empty[sel] = 1'b0;
      while (!fifo_rd[sel] && waited < 50) begin
         checkOutput("idle_tx", {31'd0, tx[sel]}, 32'd1);
         tick();
         waited++;
      end
      checkOutput("pop_seen", {31'd0, fifo_rd[sel]}, 32'd1);
      if (!fifo_rd[sel]) return;
      if (!keep_full) fifo_empty[sel] = 1'b1;
      for (int i = 0; i < lat; i++) begin
         tick();
         checkOutput("wait_rd", {31'd0, fifo_rd[sel]}, 32'd0);
         checkOutput("wait_tx", {31'd0, tx[sel]}, 32'd1);
         checkOutput("wait_busy", {31'd0, busy[sel]}, 32'd1);
      end
      fifo_valid[sel] = 1'b1;
      fifo_data[sel]  = word;
      tick();
      buildExpected(sel, word);
      n     = exp_bits.size() * CDIV;
      frame = n / bpwOf(sel);
      for (int c = 0; c < n; c++) begin
         if (c == abort_at) begin
            reset = 1'b1;
            #1;
            checkOutput("abort_tx", {31'd0, tx[sel]}, 32'd1);
            checkOutput("abort_busy", {31'd0, busy[sel]}, 32'd0);
            fifo_valid[sel] = 1'b0;
            tick();
            reset = 1'b0;
            return;
         end
         if (drop_en && c == 5) tx_en[sel] = 1'b0;
         fifo_valid[sel] = 1'($urandom_range(0, 1));
         fifo_data[sel]  = $urandom;
         checkOutput("tx_bit", {31'd0, tx[sel]}, {31'd0, exp_bits[c / CDIV]});
         checkOutput("byte_done", {31'd0, byte_done[sel]}, {31'd0, (c % frame) == frame - 1});
         checkOutput("word_done", {31'd0, word_done[sel]}, {31'd0, c == n - 1});
         checkOutput("rd_in_word", {31'd0, fifo_rd[sel]}, 32'd0);
         checkOutput("busy_in_word", {31'd0, busy[sel]}, 32'd1);
         tick();
      end
      fifo_valid[sel] = 1'b0;
      checkOutput("gap_busy", {31'd0, busy[sel]}, 32'd0);
      checkOutput("gap_tx", {31'd0, tx[sel]}, 32'd1);
      checkOutput("gap_rd", {31'd0, fifo_rd[sel]}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      tx_en      = 2'b00;
      fifo_empty = 2'b11;
      fifo_valid = 2'b00;
      fifo_data[0] = 32'd0;
      fifo_data[1] = 32'd0;
      tick();
      for (int s = 0; s < 2; s++) begin
         checkOutput("rst_tx", {31'd0, tx[s]}, 32'd1);
         checkOutput("rst_busy", {31'd0, busy[s]}, 32'd0);
         checkOutput("rst_rd", {31'd0, fifo_rd[s]}, 32'd0);
         checkOutput("rst_bdone", {31'd0, byte_done[s]}, 32'd0);
         checkOutput("rst_wdone", {31'd0, word_done[s]}, 32'd0);
      end
      reset = 1'b0;
      tick();

      $display("[TB] single word 0x44332211");
      applyStimulus(0, 32'h44332211, 0, 1'b0, 1'b0, -1);

      $display("[TB] back-to-back words with 3-cycle fifo latency");
      applyStimulus(0, 32'h000000A5, 3, 1'b1, 1'b0, -1);
      applyStimulus(0, 32'hFFFFFFFF, 3, 1'b0, 1'b0, -1);

      $display("[TB] parity instance: 0x07, 0x03, random bytes");
      applyStimulus(1, 32'h00000007, 1, 1'b0, 1'b0, -1);
      applyStimulus(1, 32'h00000003, 2, 1'b0, 1'b0, -1);
      for (int k = 0; k < 4; k++)
         applyStimulus(1, $urandom, $urandom_range(0, 5), 1'b0, 1'b0, -1);
      tx_en[1] = 1'b0;

      $display("[TB] empty fifo and disabled transmitter");
      tx_en[0]      = 1'b1;
      fifo_empty[0] = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         checkOutput("empty_rd", {31'd0, fifo_rd[0]}, 32'd0);
         checkOutput("empty_busy", {31'd0, busy[0]}, 32'd0);
         checkOutput("empty_tx", {31'd0, tx[0]}, 32'd1);
      end
      tx_en[0]      = 1'b0;
      fifo_empty[0] = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         checkOutput("disabled_rd", {31'd0, fifo_rd[0]}, 32'd0);
         checkOutput("disabled_busy", {31'd0, busy[0]}, 32'd0);
         checkOutput("disabled_tx", {31'd0, tx[0]}, 32'd1);
      end

      $display("[TB] reset during data bit 3 of byte 1, then a fresh word");
      applyStimulus(0, 32'hDEADBEEF, 1, 1'b0, 1'b0, 57);
      applyStimulus(0, 32'hCAFEF00D, 0, 1'b0, 1'b0, -1);

      $display("[TB] tx_en dropped during byte 0");
      applyStimulus(0, $urandom, 2, 1'b1, 1'b1, -1);
      for (int c = 0; c < 30; c++) begin
         tick();
         checkOutput("dropped_rd", {31'd0, fifo_rd[0]}, 32'd0);
         checkOutput("dropped_busy", {31'd0, busy[0]}, 32'd0);
      end

      $display("[TB] random words on the 8N1 instance");
      for (int k = 0; k < 3; k++)
         applyStimulus(0, $urandom, $urandom_range(0, 6), 1'b0, 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream consumer of the UART transmit FIFO: pops 32-bit words and shifts each out on the serial line as BYTES_PER_WORD asynchronous frames.
- Frames are byte 0 first (bits [7:0]), LSB first.
- Generates its own bit timing from clk through an integer divider.
- Drives the UART tx pin and reports busy and completion status to the CSR block.

Parameters:
- CLK_DIV, 16, clk cycles per serial bit; legal range >= 2.
- BYTES_PER_WORD, 4, bytes sent per popped word; legal values 1..4.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tx_en  input  1  transmit enable; sampled only in IDLE
- fifo_empty  input  1  FIFO holds no words
- fifo_rd  output  1  one-cycle pop request to the FIFO
- fifo_valid  input  1  fifo_data is valid this cycle; may arrive any number of cycles after fifo_rd
- fifo_data  input  32  popped word
- tx  output  1  serial line; idle high
- busy  output  1  high in every state except IDLE
- byte_done  output  1  one-cycle pulse at the end of each frame's last stop bit
- word_done  output  1  one-cycle pulse coincident with the byte_done of the final byte of a word

Behaviour:
- Reset (asynchronous, takes effect immediately): tx = 1, fifo_rd = 0, busy = 0, byte_done = 0, word_done = 0, state = IDLE, counters and shift register cleared.
- Reset asserted mid-frame aborts the frame; the partially sent word is discarded.
- All outputs are registered.
- IDLE: when tx_en = 1 and fifo_empty = 0, assert fifo_rd for exactly one cycle and go to WAIT.
- WAIT: fifo_rd = 0. On the first cycle fifo_valid = 1, capture fifo_data into the shift register, set byte_idx = 0, and go to START. There is no timeout.
- fifo_valid outside WAIT is ignored.
- START: tx = 0 for CLK_DIV cycles. tx falls on the clk edge that enters START.
- DATA: 8 bits, LSB first, CLK_DIV cycles each; bit counter 0..7.
- PARITY (only when PARITY_EN = 1): one bit, CLK_DIV cycles.
  - Even parity: tx = XOR of the 8 data bits.
  - Odd parity: the inverse.
- STOP: tx = 1 for STOP_BITS × CLK_DIV cycles. On the last cycle of the final stop bit, pulse byte_done.
  - If byte_idx < BYTES_PER_WORD-1: increment byte_idx, shift the word right 8 bits, go straight to START. There is no idle gap between bytes.
  - Else: pulse word_done and return to IDLE.
- Baud counter:
  - Width $clog2(CLK_DIV); loads CLK_DIV-1 on every bit entry and decrements to 0.
  - The bit ends on the cycle the counter equals 0; no wrap or overflow beyond that.
- Frame length: (1 + 8 + PARITY_EN + STOP_BITS) × CLK_DIV cycles exactly.
- Word-to-word gap after word_done: at least 1 IDLE cycle, 1 cycle with fifo_rd, then the WAIT duration. tx stays high throughout.
- Bytes above BYTES_PER_WORD-1 are never transmitted.
- tx_en deasserted mid-word: the current word completes in full; no new pop occurs.
- fifo_empty rising mid-word: no effect on the current word.
- fifo_rd is never asserted while busy, except the single IDLE→WAIT cycle. At most one outstanding pop at any time.

Test Plan:
- CLK_DIV=4, defaults, FIFO holds 0x44332211, tx_en=1:
  - fifo_rd pulses once; tx sends bytes 0x11, 0x22, 0x33, 0x44, each 8N1.
  - 40 cycles per byte, 160 contiguous cycles; 4 byte_done pulses; word_done coincides with the 4th byte_done.
- Two words 0x000000A5 then 0xFFFFFFFF, fifo_valid 3 cycles after fifo_rd:
  - Second fifo_rd occurs only after the first word_done; tx high across the gap.
  - Bit pattern of 0xA5 on the line: 0,1,0,1,0,0,1,0,1,1.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, BYTES_PER_WORD=1, word 0x07:
  - Frame start, 1,1,1,0,0,0,0,0, parity 1, stop, stop: 12 bits × CLK_DIV cycles.
  - Byte 0x03 in the same configuration gives parity 0.
- fifo_empty=1, tx_en=1 for 100 cycles: fifo_rd never asserts, busy=0, tx=1. tx_en=0 with the FIFO non-empty gives the same result.
- Reset pulsed during DATA bit 3 of byte 1:
  - tx=1 and busy=0 on the same cycle.
  - After release with the FIFO non-empty, the next pop starts a fresh word at byte 0.
- tx_en dropped during byte 0: all 4 bytes still sent, word_done pulses, no further fifo_rd, state returns to IDLE.
